host_tx_port: RTL and testbench

- Wishbone B3 classic slave that lets the CPU send bytes back to the host over the byte-stream link.
- This is the reverse direction of the host loader: host_ctrl turns host bytes into Wishbone writes; this block turns CPU Wishbone writes into host bytes.
- Each write to TXDATA enqueues a 32-bit word plus its byte selects into a small FIFO.
- A serializer drains the FIFO and emits the selected bytes LSB-first on a valid/ready byte interface that feeds the UART transmitter.

---
 rtl/host_tx_port.sv | 154 +++++++++++++++
 tb/tb_host_tx_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/host_tx_port.sv
// host_tx_port
//   Wishbone B3 classic slave that carries CPU-written words back to the host.
//   A TXDATA write queues {data, byte selects} in a word FIFO. A serializer
//   drains the FIFO and emits the selected bytes LSB-first on a valid/ready
//   byte stream that feeds the UART transmitter.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   wb_adr_i[2]        register select: 0 = TXDATA, 1 = STATUS
//   wb_dat_i/wb_dat_o  write / read data (read data is 0 while ack is low)
//   wb_sel_i           byte lane selects (TXDATA: which bytes get sent)
//   wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o   classic single-cycle handshake
//   tx_data_o, tx_valid_o, tx_ready_i       byte stream to the UART
//   tx_busy_o          FIFO non-empty or serializer mid-word
//
// STATUS layout: [7:0] level, [8] full, [9] empty, [10] overflow,
//   [11] serializer busy. Writing 1 to bit 10 clears overflow.
module host_tx_port #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        tx_busy_o
);

    localparam logic [ADDR_W:0] DEPTH_L = FIFO_DEPTH[ADDR_W:0];

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state, state_next;
    logic [31:0]       mem_data [FIFO_DEPTH];
    logic [3:0]        mem_sel  [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic [31:0]       shift_word;
    logic [3:0]        lane_mask;
    logic [1:0]        idx;

    logic        req, sel_status, full, empty, push, pop, drop;
    logic        lane_on, step, ser_busy, clr_ovf;
    logic [7:0]  level_byte;
    logic [31:0] status_word;
    logic        unused_adr;

    assign unused_adr = ^{wb_adr_i[31:3], wb_adr_i[1:0]};

    // A request is only taken while ack is low, so a held strobe is
    // serviced every other cycle.
    assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign sel_status = wb_adr_i[2];
    assign full       = (level == DEPTH_L);
    assign empty      = (level == '0);
    assign ser_busy   = (state != IDLE);

    // Full is judged before any same-edge pop, so a write to a full FIFO is
    // dropped even when the serializer frees a slot on that edge.
    assign push    = req & wb_we_i & ~sel_status & (|wb_sel_i) & ~full;
    assign drop    = req & wb_we_i & ~sel_status & (|wb_sel_i) & full;
    assign clr_ovf = req & wb_we_i & sel_status & wb_dat_i[10];
    assign pop     = (state == IDLE) & ~empty;

    assign lane_on = lane_mask[idx];
    // A skipped lane costs one cycle; a selected lane waits for ready.
    assign step    = (state == SEND) & (~lane_on | tx_ready_i);

    assign level_byte  = 8'(level);
    assign status_word = {20'd0, ser_busy, overflow, empty, full, level_byte};
    assign tx_busy_o   = ~empty | ser_busy;

    // FIFO storage carries data only, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wr_ptr] <= wb_dat_i;
            mem_sel[wr_ptr]  <= wb_sel_i;
        end
        if (pop) begin
            shift_word <= mem_data[rd_ptr];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= (req & ~wb_we_i & sel_status) ? status_word : 32'd0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // Serializer state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            idx       <= 2'd0;
            lane_mask <= 4'd0;
        end else begin
            state <= state_next;
            if (pop) begin
                idx       <= 2'd0;
                lane_mask <= mem_sel[rd_ptr];
            end else if (step) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Serializer next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pop) state_next = SEND;
            SEND:    if (step && idx == 2'd3) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Serializer outputs; data is forced to 0 whenever no byte is offered.
    always_comb begin
        tx_valid_o = 1'b0;
        tx_data_o  = 8'd0;
        if (state == SEND && lane_on) begin
            tx_valid_o = 1'b1;
            tx_data_o  = shift_word[{idx, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_host_tx_port.sv
module tb_host_tx_port;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] wb_adr = '0, wb_dat_w = '0, wb_dat_r;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0, wb_ack;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_busy;
    logic        tx_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_mode = 0;   // 0 = held, 1 = toggle each cycle, 2 = random
    byte unsigned exp_q[$];

    host_tx_port #(.FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r),
        .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(wb_cyc),
        .wb_stb_i(wb_stb), .wb_ack_o(wb_ack),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .tx_busy_o(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_mode == 1) tx_ready = ~tx_ready;
        else if (rdy_mode == 2) tx_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference: a word turns into its selected bytes, lowest lane first.
    task automatic expect_word(input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++)
            if (s[i]) exp_q.push_back(d[8*i +: 8]);
    endtask

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdata, output int lat);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
        tick();
        lat = 1;
        while (!wb_ack && lat < 8) begin
            tick();
            lat++;
        end
        chk("ack", 32'(wb_ack), 1);
        rdata = wb_dat_r;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    // Byte monitor: checks every handshake against the reference queue and
    // that a stalled byte is held unchanged.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(tx_valid), 1);
                chk("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                chk("byte_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            prev_stall = tx_valid & ~tx_ready;
            prev_data  = tx_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, d;
        logic [3:0]  s;
        int lat, guard;

        // Reset state
        repeat (2) tick();
        chk("rst_ack", 32'(wb_ack), 0);
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_dat", wb_dat_r, 0);
        rst_ni = 1'b1;
        tick();

        // Full word, ready held high
        tx_ready = 1'b1;
        expect_word(32'h44332211, 4'hF);
        bus(1'b1, 32'h0, 32'h44332211, 4'hF, rd, lat);
        chk("ack_lat", 32'(lat), 1);
        tick();
        chk("ack_low", 32'(wb_ack), 0);
        chk("b0_valid", 32'(tx_valid), 1);
        chk("b0_data", 32'(tx_data), 32'h11);
        tick(); chk("b1_data", 32'(tx_data), 32'h22);
        tick(); chk("b2_data", 32'(tx_data), 32'h33);
        tick(); chk("b3_data", 32'(tx_data), 32'h44);
        tick();
        chk("w1_done_valid", 32'(tx_valid), 0);
        chk("w1_done_busy", 32'(tx_busy), 0);

        // Sparse lanes
        expect_word(32'hAABBCCDD, 4'b0101);
        bus(1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, rd, lat);
        tick(); chk("s0_data", 32'(tx_data), 32'hDD);
        tick(); chk("s1_skip", 32'(tx_valid), 0);
        tick(); chk("s2_data", 32'(tx_data), 32'hBB);
        tick(); chk("s3_skip", 32'(tx_valid), 0);
        tick(); chk("s_done_busy", 32'(tx_busy), 0);

        // Overflow with the sink stalled: one word in the serializer,
        // DEPTH in the FIFO, the rest dropped.
        tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            d = 32'h10203040 + 32'(k) * 32'h01010101;
            if (k < DEPTH + 1) expect_word(d, 4'hF);
            bus(1'b1, 32'h0, d, 4'hF, rd, lat);
        end
        bus(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
        chk("ovf_status", rd, 32'h00000D04);
        bus(1'b1, 32'h4, 32'h400, 4'hF, rd, lat);
        bus(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
        chk("ovf_cleared", rd, 32'h00000904);
        tx_ready = 1'b1;
        guard = 0;
        while (tx_busy && guard < 200) begin tick(); guard++; end
        chk("ovf_drain_time", 32'(guard < 200), 1);
        chk("ovf_drained", 32'(exp_q.size()), 0);

        // Backpressure: ready toggles every cycle
        tx_ready = 1'b0;
        expect_word(32'h0D0C0B0A, 4'hF);
        bus(1'b1, 32'h0, 32'h0D0C0B0A, 4'hF, rd, lat);
        rdy_mode = 1;
        repeat (20) tick();
        rdy_mode = 0;
        chk("bp_drained", 32'(exp_q.size()), 0);

        // Zero byte selects and TXDATA read
        tx_ready = 1'b1;
        bus(1'b1, 32'h0, 32'hDEADBEEF, 4'h0, rd, lat);
        bus(1'b0, 32'h0, 32'h0, 4'hF, rd, lat);
        chk("txdata_read", rd, 0);
        tick();
        chk("sel0_busy", 32'(tx_busy), 0);
        bus(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
        chk("sel0_status", rd, 32'h00000200);

        // Randomized traffic with random sink readiness
        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            guard = 0;
            bus(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
            while (rd[7:0] >= 8'(DEPTH) && guard < 50) begin
                bus(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
                guard++;
            end
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            expect_word(d, s);
            bus(1'b1, 32'h0, d, s, rd, lat);
            repeat ($urandom_range(0, 3)) tick();
        end
        guard = 0;
        while ((tx_busy || exp_q.size() != 0) && guard < 1000) begin tick(); guard++; end
        rdy_mode = 0;
        chk("rand_drained", 32'(exp_q.size()), 0);
        bus(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
        chk("rand_status", rd, 32'h00000200);

        // Reset mid-word with a byte on offer and an ack high
        tx_ready = 1'b0;
        bus(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, lat);
        guard = 0;
        while (!tx_valid && guard < 5) begin tick(); guard++; end
        chk("mid_valid", 32'(tx_valid), 1);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h4;
        tick();
        chk("mid_ack", 32'(wb_ack), 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_valid", 32'(tx_valid), 0);
        chk("arst_ack", 32'(wb_ack), 0);
        chk("arst_busy", 32'(tx_busy), 0);
        chk("arst_dat", wb_dat_r, 0);
        exp_q.delete();
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
        tx_ready = 1'b1;
        tick();
        bus(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
        chk("post_rst_status", rd, 32'h00000200);
        repeat (8) tick();
        chk("post_rst_quiet", 32'(tx_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
